htif_burst: RTL and testbench

//   Parametrised successor to the byte-stream host interface: turns a host byte

---
 rtl/htif_burst.sv | 191 +++++++++++++++++++
 tb/tb_htif_burst.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htif_burst.sv
// Host byte-stream to memory-bus bridge: set-address, auto-incrementing burst
// writes (acked with one byte) and burst reads (returned little-endian).
module htif_burst #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4,
    parameter int BURST_BITS = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    rx_ready,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    bus_req_ready,
    output logic                    bus_req_read,
    output logic                    bus_req_write,
    output logic [8*ADDR_BYTES-1:0] bus_req_address,
    output logic [8*DATA_BYTES-1:0] bus_req_data,
    input  logic                    bus_res_valid,
    input  logic [8*DATA_BYTES-1:0] bus_res_data,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic [3:0]              htif_state
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [7:0] LAST_A = 8'(ADDR_BYTES - 1);
    localparam logic [7:0] LAST_D = 8'(DATA_BYTES - 1);

    typedef enum logic [3:0] {
        S_CMD   = 4'd0,
        S_ADDR  = 4'd1,
        S_WDATA = 4'd2,
        S_WREQ  = 4'd3,
        S_RREQ  = 4'd4,
        S_RWAIT = 4'd5,
        S_RTX   = 4'd6,
        S_ACK   = 4'd7
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_addr;
    logic [AW-1:0]         r_stage;
    logic [DW-1:0]         r_wdata;
    logic [DW-1:0]         r_rdata;
    logic [7:0]            r_cnt;
    logic [BURST_BITS-1:0] r_n;
    logic [BURST_BITS-1:0] r_beats;
    logic                  r_rx_ready;
    logic                  r_read;
    logic                  r_write;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;
    logic                  w_rx_take;

    assign w_rx_take       = rx_valid & r_rx_ready;
    assign rx_ready        = r_rx_ready;
    assign bus_req_read    = r_read;
    assign bus_req_write   = r_write;
    assign bus_req_address = r_addr;
    assign bus_req_data    = r_wdata;
    assign tx_valid        = r_tx_valid;
    assign tx_data         = r_tx_data;
    assign htif_state      = r_state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_CMD;
            r_addr     <= '0;
            r_stage    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_n        <= '0;
            r_beats    <= '0;
            r_rx_ready <= 1'b0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                S_CMD: begin
                    // rx_ready comes up here on the first clock after reset release
                    r_rx_ready <= 1'b1;
                    if (w_rx_take) begin
                        r_n     <= rx_data[BURST_BITS-1:0];
                        r_beats <= rx_data[BURST_BITS-1:0];
                        r_cnt   <= '0;
                        case (rx_data[7:6])
                            2'b01: begin
                                r_state <= S_ADDR;
                                r_stage <= '0;
                            end
                            2'b10: r_state <= S_WDATA;
                            2'b11: begin
                                r_state    <= S_RREQ;
                                r_rx_ready <= 1'b0;
                                r_read     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_rx_take) begin
                        if (r_cnt == LAST_A) begin
                            r_addr  <= r_stage | (AW'(rx_data) << (8 * (ADDR_BYTES - 1)));
                            r_state <= S_CMD;
                        end else begin
                            r_stage[8*r_cnt +: 8] <= rx_data;
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_rx_take) begin
                        r_wdata[8*r_cnt +: 8] <= rx_data;
                        if (r_cnt == LAST_D) begin
                            r_cnt      <= '0;
                            r_state    <= S_WREQ;
                            r_rx_ready <= 1'b0;
                            r_write    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_WREQ: begin
                    if (bus_req_ready) begin
                        r_write <= 1'b0;
                        r_addr  <= r_addr + AW'(DATA_BYTES);
                        if (r_beats == '0) begin
                            r_state    <= S_ACK;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= {2'b10, 6'(r_n)};
                        end else begin
                            r_beats    <= r_beats - 1'b1;
                            r_state    <= S_WDATA;
                            r_rx_ready <= 1'b1;
                        end
                    end
                end
                S_RREQ: begin
                    if (bus_req_ready) begin
                        r_read  <= 1'b0;
                        r_addr  <= r_addr + AW'(DATA_BYTES);
                        r_state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (bus_res_valid) begin
                        r_tx_data  <= bus_res_data[7:0];
                        r_rdata    <= bus_res_data >> 8;
                        r_tx_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_RTX;
                    end
                end
                S_RTX: begin
                    // Latched beat drains one byte per accepted transfer, LSB first
                    if (tx_ready) begin
                        if (r_cnt == LAST_D) begin
                            r_tx_valid <= 1'b0;
                            if (r_beats == '0) begin
                                r_state    <= S_CMD;
                                r_rx_ready <= 1'b1;
                            end else begin
                                r_beats <= r_beats - 1'b1;
                                r_state <= S_RREQ;
                                r_read  <= 1'b1;
                            end
                        end else begin
                            r_tx_data <= r_rdata[7:0];
                            r_rdata   <= r_rdata >> 8;
                            r_cnt     <= r_cnt + 8'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_CMD;
                        r_rx_ready <= 1'b1;
                    end
                end
                default: r_state <= S_CMD;
            endcase
        end
    end
endmodule

// File: tb/tb_htif_burst.sv
// Bench for htif_burst: host/bus/tx agents with random back-pressure and a
// transaction-level model of address progression, write beats, acks and read bytes.
`timescale 1ns/1ps
module tb_htif_burst;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_ready, rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        bus_req_ready = 1'b0, bus_req_read, bus_req_write;
    logic [31:0] bus_req_address, bus_req_data;
    logic        bus_res_valid = 1'b0;
    logic [31:0] bus_res_data = '0;
    logic        tx_ready = 1'b0, tx_valid;
    logic [7:0]  tx_data;
    logic [3:0]  htif_state;

    int checks = 0;
    int passes = 0;

    logic [31:0] wq_a[$], wq_d[$], rq_a[$], wbuf[$];
    logic [7:0]  txq[$];
    logic [31:0] m_addr;
    bit hold_req = 0, req_rand = 0, tx_rand = 0, resp_en = 1, force_tog = 0;

    htif_burst #(.ADDR_BYTES(4), .DATA_BYTES(4), .BURST_BITS(6)) dut (
        .clock(clock), .reset(reset),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .bus_req_ready(bus_req_ready), .bus_req_read(bus_req_read),
        .bus_req_write(bus_req_write), .bus_req_address(bus_req_address),
        .bus_req_data(bus_req_data), .bus_res_valid(bus_res_valid),
        .bus_res_data(bus_res_data), .tx_ready(tx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .htif_state(htif_state)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF ^ {a[31:16], a[31:16]};
    endfunction

    // Bus/tx agent: records transfers at negedge, drives responses after posedge
    initial begin : agent
        bit pend = 0, seen = 0;
        int dly = 0;
        logic [31:0] paddr = '0;
        forever begin
            @(negedge clock);
            if (!reset) pend = 0;
            else begin
                if (bus_req_write && bus_req_ready) begin
                    wq_a.push_back(bus_req_address);
                    wq_d.push_back(bus_req_data);
                end
                if (bus_req_read && bus_req_ready) begin
                    rq_a.push_back(bus_req_address);
                    pend = 1; paddr = bus_req_address; dly = $urandom_range(0, 3);
                end
                if (tx_valid && tx_ready) txq.push_back(tx_data);
            end
            @(posedge clock); #1;
            bus_res_valid = 1'b0;
            if (force_tog != seen) begin
                seen = force_tog; bus_res_valid = 1'b1; bus_res_data = $urandom;
            end else if (pend && resp_en) begin
                if (dly == 0) begin
                    bus_res_valid = 1'b1; bus_res_data = rd_word(paddr); pend = 0;
                end else dly--;
            end
            bus_req_ready = hold_req ? 1'b0 : (req_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clear_q();
        wq_a.delete(); wq_d.delete(); rq_a.delete(); txq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1; rx_data = b;
        do begin @(negedge clock); t++; end while (!rx_ready && t < 500);
        @(posedge clock); #1;
        rx_valid = 1'b0;
        if (t >= 500) begin
            checks++;
            $display("FAIL rx_timeout byte %02h never accepted", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic run_setaddr(input logic [31:0] a);
        send_byte(8'h40); send_word(a);
    endtask

    task automatic run_write(input logic [5:0] n);
        send_byte({2'b10, n});
        foreach (wbuf[i]) send_word(wbuf[i]);
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while (txq.size() < n && t < 3000) begin @(posedge clock); #1; t++; end
        if (txq.size() < n) begin
            checks++;
            $display("FAIL tx_timeout got %0d bytes need %0d", txq.size(), n);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({rx_ready, bus_req_read, bus_req_write, tx_valid, htif_state} !== 8'h00)
            $display("FAIL reset_outs got %b need 0", {rx_ready, bus_req_read, bus_req_write, tx_valid, htif_state});
        else passes++;
        checks++;
        if (bus_req_address !== 32'h0) $display("FAIL reset_addr got %h need 0", bus_req_address);
        else passes++;
        repeat (3) @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock); #1;
        checks++;
        if (rx_ready !== 1'b1 || htif_state !== 4'd0)
            $display("FAIL post_reset rx_ready=%b state=%0d need 1,0", rx_ready, htif_state);
        else passes++;
        m_addr = 32'h0;
    endtask

    task automatic test_setaddr();
        logic [31:0] got;
        clear_q();
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        repeat (5) @(posedge clock); #1;
        checks++;
        if (wq_a.size() + rq_a.size() + txq.size() != 0)
            $display("FAIL setaddr_quiet got %0d events need 0", wq_a.size() + rq_a.size() + txq.size());
        else passes++;
        send_byte(8'hC0);
        wait_tx(4);
        checks++;
        if (rq_a.size() != 1 || rq_a[0] !== 32'h0000_1000)
            $display("FAIL setaddr_read got %h (n=%0d) need 00001000", rq_a[0], rq_a.size());
        else passes++;
        got = {txq[3], txq[2], txq[1], txq[0]};
        checks++;
        if (got !== rd_word(32'h1000)) $display("FAIL setaddr_rdata got %h need %h", got, rd_word(32'h1000));
        else passes++;
        m_addr = 32'h1004;
    endtask

    task automatic test_write();
        clear_q();
        run_setaddr(32'h1000);
        send_byte(8'h81);
        for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));
        wait_tx(1);
        checks++;
        if (wq_a.size() != 2 || wq_a[0] !== 32'h1000 || wq_d[0] !== 32'h4433_2211)
            $display("FAIL write_beat0 got %h@%h need 44332211@00001000", wq_d[0], wq_a[0]);
        else passes++;
        checks++;
        if (wq_a[1] !== 32'h1004 || wq_d[1] !== 32'h8877_6655)
            $display("FAIL write_beat1 got %h@%h need 88776655@00001004", wq_d[1], wq_a[1]);
        else passes++;
        checks++;
        if (txq[0] !== 8'h81) $display("FAIL write_ack got %h need 81", txq[0]);
        else passes++;
        clear_q();
        send_byte(8'hC0);
        wait_tx(4);
        checks++;
        if (rq_a[0] !== 32'h1008) $display("FAIL write_continue got %h need 00001008", rq_a[0]);
        else passes++;
        m_addr = 32'h100C;
    endtask

    task automatic test_read_burst();
        logic [31:0] w;
        clear_q();
        tx_rand = 1;
        run_setaddr(32'h2000);
        send_byte(8'hC2);
        wait_tx(12);
        repeat (10) @(posedge clock); #1;
        checks++;
        if (txq.size() != 12 || rq_a.size() != 3)
            $display("FAIL rburst_counts got tx=%0d rd=%0d need 12,3", txq.size(), rq_a.size());
        else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rq_a[i] !== 32'h2000 + 32'(4 * i)) $display("FAIL rburst_addr%0d got %h need %h", i, rq_a[i], 32'h2000 + 32'(4 * i));
            else passes++;
        end
        for (int i = 0; i < 12; i++) begin
            w = rd_word(32'h2000 + 32'(4 * (i / 4)));
            checks++;
            if (txq[i] !== w[8*(i%4) +: 8]) $display("FAIL rburst_byte%0d got %h need %h", i, txq[i], w[8*(i%4) +: 8]);
            else passes++;
        end
        tx_rand = 0;
        clear_q();
        send_byte(8'hC0);
        wait_tx(4);
        checks++;
        if (rq_a[0] !== 32'h200C) $display("FAIL rburst_end got %h need 0000200C", rq_a[0]);
        else passes++;
        m_addr = 32'h2010;
    endtask

    task automatic test_wrap();
        clear_q();
        wbuf.delete(); wbuf.push_back($urandom); wbuf.push_back($urandom);
        run_setaddr(32'hFFFF_FFFC);
        run_write(6'd1);
        wait_tx(1);
        checks++;
        if (wq_a.size() != 2 || wq_a[0] !== 32'hFFFF_FFFC || wq_a[1] !== 32'h0)
            $display("FAIL wrap_addr got %h,%h need fffffffc,00000000", wq_a[0], wq_a[1]);
        else passes++;
        checks++;
        if (wq_d[0] !== wbuf[0] || wq_d[1] !== wbuf[1])
            $display("FAIL wrap_data got %h,%h need %h,%h", wq_d[0], wq_d[1], wbuf[0], wbuf[1]);
        else passes++;
        m_addr = 32'h4;
    endtask

    task automatic test_stall();
        logic [31:0] a0, d0, w;
        bit ok = 1;
        int t = 0;
        clear_q();
        w = $urandom;
        hold_req = 1;
        send_byte(8'h80); send_word(w);
        while (!bus_req_write && t < 100) begin @(posedge clock); #1; t++; end
        a0 = bus_req_address; d0 = bus_req_data;
        repeat (10) begin
            @(posedge clock); #1;
            if (!(bus_req_write === 1'b1 && bus_req_read === 1'b0 && rx_ready === 1'b0 &&
                  bus_req_address === a0 && bus_req_data === d0 && htif_state === 4'd3)) ok = 0;
        end
        checks++;
        if (!ok || a0 !== m_addr || d0 !== w)
            $display("FAIL stall_hold got ok=%0d %h@%h need 1 %h@%h", ok, d0, a0, w, m_addr);
        else passes++;
        hold_req = 0;
        wait_tx(1);
        checks++;
        if (wq_a.size() != 1 || wq_d[0] !== w || txq[0] !== 8'h80)
            $display("FAIL stall_release got n=%0d %h ack %h need 1 %h 80", wq_a.size(), wq_d[0], txq[0], w);
        else passes++;
        m_addr = m_addr + 32'd4;
    endtask

    task automatic test_random();
        int op, n;
        logic [31:0] w;
        req_rand = 1; tx_rand = 1;
        for (int k = 0; k < 10; k++) begin
            op = $urandom_range(0, 2); n = $urandom_range(0, 3);
            clear_q();
            if (op == 0) begin
                w = $urandom;
                run_setaddr(w);
                send_byte(8'h3F);
                m_addr = w;
                repeat (4) @(posedge clock); #1;
                checks++;
                if (txq.size() + wq_a.size() + rq_a.size() != 0)
                    $display("FAIL rnd_setaddr_quiet k=%0d got %0d events", k, txq.size() + wq_a.size() + rq_a.size());
                else passes++;
            end else if (op == 1) begin
                wbuf.delete();
                for (int b = 0; b <= n; b++) wbuf.push_back($urandom);
                run_write(6'(n));
                wait_tx(1);
                checks++;
                if (wq_a.size() != n + 1 || txq[0] !== (8'h80 | 8'(n)))
                    $display("FAIL rnd_write_cnt k=%0d got %0d beats ack %h need %0d %h", k, wq_a.size(), txq[0], n + 1, 8'h80 | 8'(n));
                else passes++;
                for (int b = 0; b <= n; b++) begin
                    checks++;
                    if (wq_a[b] !== m_addr || wq_d[b] !== wbuf[b])
                        $display("FAIL rnd_write k=%0d beat %0d got %h@%h need %h@%h", k, b, wq_d[b], wq_a[b], wbuf[b], m_addr);
                    else passes++;
                    m_addr = m_addr + 32'd4;
                end
            end else begin
                send_byte({2'b11, 6'(n)});
                wait_tx(4 * (n + 1));
                for (int b = 0; b <= n; b++) begin
                    w = {txq[4*b+3], txq[4*b+2], txq[4*b+1], txq[4*b]};
                    checks++;
                    if (rq_a[b] !== m_addr || w !== rd_word(m_addr))
                        $display("FAIL rnd_read k=%0d beat %0d got %h@%h need %h@%h", k, b, w, rq_a[b], rd_word(m_addr), m_addr);
                    else passes++;
                    m_addr = m_addr + 32'd4;
                end
            end
        end
        req_rand = 0; tx_rand = 0;
        repeat (10) @(posedge clock); #1;
    endtask

    task automatic test_spurious();
        clear_q();
        force_tog = ~force_tog;
        repeat (6) @(posedge clock); #1;
        checks++;
        if (txq.size() != 0 || htif_state !== 4'd0)
            $display("FAIL spurious got tx=%0d state=%0d need 0,0", txq.size(), htif_state);
        else passes++;
    endtask

    task automatic test_reset_rwait();
        int t = 0;
        clear_q();
        resp_en = 0;
        send_byte(8'hC1);
        while (htif_state !== 4'd5 && t < 100) begin @(posedge clock); #1; t++; end
        reset = 1'b0;
        #1;
        checks++;
        if (htif_state !== 4'd0 || tx_valid !== 1'b0 || bus_req_read !== 1'b0)
            $display("FAIL rst_rwait got state=%0d tx_valid=%b rd=%b need 0,0,0", htif_state, tx_valid, bus_req_read);
        else passes++;
        @(posedge clock); #1;
        reset = 1'b1;
        resp_en = 1;
        force_tog = ~force_tog;
        repeat (20) @(posedge clock); #1;
        checks++;
        if (txq.size() != 0 || htif_state !== 4'd0 || rq_a.size() != 1)
            $display("FAIL rst_abort got tx=%0d state=%0d rd=%0d need 0,0,1", txq.size(), htif_state, rq_a.size());
        else passes++;
        m_addr = 32'h0;
        clear_q();
        send_byte(8'hC0);
        wait_tx(4);
        checks++;
        if (rq_a[0] !== m_addr || {txq[3], txq[2], txq[1], txq[0]} !== rd_word(m_addr))
            $display("FAIL rst_after got %h need read at %h", rq_a[0], m_addr);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_setaddr();
        test_write();
        test_read_burst();
        test_wrap();
        test_stall();
        test_random();
        test_spurious();
        test_reset_rwait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
